// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-ported memory with MEM_LAT read latency.
// Optional misaligned-address trap enabled by defining MEM_ARB_ALIGN_CHECK_EN.
module mem_port_arbiter #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              addr_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  localparam logic [1:0] LAT_LAST   = 2'(MEM_LAT - 1);
  localparam logic       SINGLE_LAT = (MEM_LAT == 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        starve_q, starve_d;
  logic [1:0]        lat_q, lat_d;
  logic              owner_q;  // 1 = data port owns the current transaction
  logic              we_q;
  logic              err_q;
  logic [DATA_W-1:0] mem_addr_q, mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic in_idle, if_wins, grant_if, grant_d, grant_any, grant_misaligned, capture;

  assign in_idle   = (state_q == IDLE);
  assign if_wins   = if_req && (!d_req || (starve_q >= STARVE_LIM));
  assign grant_if  = in_idle && if_wins;
  assign grant_d   = in_idle && d_req && !if_wins;
  assign grant_any = grant_if || grant_d;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign grant_misaligned = grant_d ? d_addr[0] : if_addr[0];
`else
  assign grant_misaligned = 1'b0;
`endif

  // Read data is taken at the end of the last memory cycle (A + MEM_LAT - 1).
  assign capture = !we_q && (((state_q == ACCESS) && SINGLE_LAT) ||
                             ((state_q == WAIT) && (lat_q == LAT_LAST)));

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        if (grant_any) state_d = grant_misaligned ? RESP : ACCESS;
      end
      ACCESS: begin
        lat_d   = 2'd1;
        state_d = (we_q || SINGLE_LAT) ? RESP : WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_LAST) state_d = RESP;
        else                   lat_d   = lat_q + 2'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (in_idle) begin
      if (!if_req || grant_if) begin
        starve_d = '0;
      end else if (grant_d && (starve_q < STARVE_LIM)) begin
        starve_d = starve_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      lat_q       <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lat_q    <= lat_d;
      if (grant_any) begin
        owner_q <= grant_d;
        we_q    <= grant_d && d_we;
        err_q   <= grant_misaligned;
        if (!grant_misaligned) begin
          mem_addr_q <= grant_d ? d_addr : if_addr;
          if (grant_d) mem_wdata_q <= d_wdata;
        end else if (grant_d) begin
          d_rdata_q <= '0;
        end else begin
          if_rdata_q <= '0;
        end
      end
      if (capture) begin
        if (owner_q) d_rdata_q  <= mem_rdata;
        else         if_rdata_q <= mem_rdata;
      end
      if ((state_q == ACCESS) && we_q) d_rdata_q <= '0;
    end
  end

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign if_rvalid = (state_q == RESP) && !owner_q;
  assign d_rvalid  = (state_q == RESP) && owner_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign busy      = !in_idle;
  assign addr_err  = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: one MEM_LAT=1 instance with a scoreboard,
// one MEM_LAT=3 instance for latency and mid-transaction reset.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we, busy, addr_err;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if_req3, d_req3, d_we3;
  logic [15:0] if_addr3, d_addr3, d_wdata3;
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_we3, busy3, addr_err3;
  logic [15:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  mem_port_arbiter #(.DATA_W(16), .MEM_LAT(1), .STARVE_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .addr_err(addr_err)
  );

  mem_port_arbiter #(.DATA_W(16), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clock(clock), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3),
    .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_gnt(d_gnt3),
    .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3), .mem_rdata(mem_rdata3),
    .busy(busy3), .addr_err(addr_err3)
  );

  // Latency-1 memory: combinational read, write on the clock edge.
  logic [15:0] mem [0:1023];
  always @(posedge clock) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:0]];

  // Latency-3 memory: data is a fixed function of the address seen two cycles earlier.
  logic [15:0] a1, a2;
  always @(posedge clock) begin
    a1 <= mem_addr3;
    a2 <= a1;
  end
  assign mem_rdata3 = a2 ^ 16'h5A5A;

  function automatic logic [15:0] model(input logic [15:0] a);
    return {6'd0, a[9:0]} ^ 16'hA5A5;
  endfunction

  typedef struct {
    bit          is_d;
    logic [15:0] data;
    bit          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (if_gnt || d_gnt) begin
        checks++;
        if (if_gnt && d_gnt) begin
          errors++;
          $display("FAIL dual_grant if_gnt=%b d_gnt=%b required only one", if_gnt, d_gnt);
        end
      end
      if (if_rvalid || d_rvalid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected if_rvalid=%b d_rvalid=%b required none", if_rvalid,
                   d_rvalid);
        end else begin
          mon_e = sb.pop_front();
          if ((d_rvalid !== mon_e.is_d) || (if_rvalid === mon_e.is_d) ||
              ((mon_e.is_d ? d_rdata : if_rdata) !== mon_e.data) || (addr_err !== mon_e.err)) begin
            errors++;
            $display("FAIL sb_resp got d=%b if=%b data=%h err=%b required d=%b data=%h err=%b",
                     d_rvalid, if_rvalid, mon_e.is_d ? d_rdata : if_rdata, addr_err,
                     mon_e.is_d, mon_e.data, mon_e.err);
          end
        end
      end
    end
  end

  task automatic run_txn(input string name, input bit is_d, input bit we,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_data, input bit exp_err,
                         input int exp_lat, input int exp_we);
    int   n;
    int   we_cnt;
    bit   addr_ok;
    bit   got;
    exp_t e;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
      got = is_d ? d_gnt : if_gnt;
    end while (!got && n < 20);
    checks++;
    if (!got || n != 1) begin
      errors++;
      $display("FAIL %s_gnt cycles=%0d granted=%b required 1 cycle", name, n, got);
      @(posedge clock); #1;
      d_req = 1'b0; if_req = 1'b0;
      return;
    end
    e.is_d = is_d; e.data = exp_data; e.err = exp_err;
    sb.push_back(e);
    @(posedge clock); #1;
    d_req = 1'b0; if_req = 1'b0;
    n = 1; we_cnt = 0; addr_ok = 1'b1;
    while (n <= 10) begin
      @(negedge clock);
      if (mem_we) we_cnt++;
      if (if_rvalid || d_rvalid) break;
      if (!exp_err && mem_addr !== addr) addr_ok = 1'b0;
      n++;
    end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL %s_latency got=%0d required=%0d", name, n, exp_lat);
    end
    checks++;
    if (we_cnt != exp_we) begin
      errors++;
      $display("FAIL %s_mem_we_cycles got=%0d required=%0d", name, we_cnt, exp_we);
    end
    checks++;
    if (!addr_ok) begin
      errors++;
      $display("FAIL %s_mem_addr last=%h required=%h", name, mem_addr, addr);
    end
    @(posedge clock); #1;
  endtask

  task automatic run_lat3(input string name, input bit is_d, input logic [15:0] addr,
                          input logic [15:0] exp_data);
    if (is_d) begin
      d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = addr;
    end else begin
      if_req3 = 1'b1; if_addr3 = addr;
    end
    @(negedge clock);
    checks++;
    if ((is_d ? d_gnt3 : if_gnt3) !== 1'b1) begin
      errors++;
      $display("FAIL %s_gnt got=%b required=1", name, is_d ? d_gnt3 : if_gnt3);
    end
    @(posedge clock); #1;
    d_req3 = 1'b0; if_req3 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      checks++;
      if (mem_addr3 !== addr || mem_we3 !== 1'b0 || if_rvalid3 !== 1'b0 || d_rvalid3 !== 1'b0)
      begin
        errors++;
        $display("FAIL %s_hold_c%0d addr=%h we=%b rv=%b%b required addr=%h we=0 rv=00", name, k,
                 mem_addr3, mem_we3, if_rvalid3, d_rvalid3, addr);
      end
    end
    @(negedge clock);
    checks++;
    if ((is_d ? d_rvalid3 : if_rvalid3) !== 1'b1 || (is_d ? d_rdata3 : if_rdata3) !== exp_data)
    begin
      errors++;
      $display("FAIL %s_resp rvalid=%b data=%h required rvalid=1 data=%h", name,
               is_d ? d_rvalid3 : if_rvalid3, is_d ? d_rdata3 : if_rdata3, exp_data);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    if_req3 = 0; d_req3 = 0; d_we3 = 0; if_addr3 = 0; d_addr3 = 0; d_wdata3 = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({busy, mem_we, if_rvalid, d_rvalid, addr_err, if_gnt, d_gnt, busy3} !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required=00000000",
               {busy, mem_we, if_rvalid, d_rvalid, addr_err, if_gnt, d_gnt, busy3});
    end
    checks++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 64'd0) begin
      errors++;
      $display("FAIL reset_data got=%h required=0", {if_rdata, d_rdata, mem_addr, mem_wdata});
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_fetch();
    run_txn("fetch", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 2, 0);
  endtask

  task automatic test_write_read();
    run_txn("d_write", 1'b1, 1'b1, 16'h0200, 16'h1234, 16'h0000, 1'b0, 2, 1);
    run_txn("d_read", 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h1234, 1'b0, 2, 0);
  endtask

  task automatic test_starvation();
    bit   pattern [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int   got = 0;
    int   cyc = 0;
    exp_t e;
    if_addr = 16'h0020; d_addr = 16'h0040; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    while (got < 10 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (if_gnt || d_gnt) begin
        e.is_d = d_gnt;
        e.data = d_gnt ? model(16'h0040) : model(16'h0020);
        e.err  = 1'b0;
        sb.push_back(e);
        checks++;
        if (d_gnt !== pattern[got]) begin
          errors++;
          $display("FAIL starve_order_%0d d_gnt=%b required=%b", got, d_gnt, pattern[got]);
        end
        got++;
      end
    end
    @(posedge clock); #1;
    if_req = 1'b0; d_req = 1'b0;
    checks++;
    if (got != 10) begin
      errors++;
      $display("FAIL starve_grants got=%0d required=10", got);
    end
    cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL starve_drain pending=%0d required=0", sb.size());
      sb.delete();
    end
    @(posedge clock); #1;
  endtask

  task automatic test_misaligned();
`ifdef MEM_ARB_ALIGN_CHECK_EN
    run_txn("misalign", 1'b1, 1'b1, 16'h0201, 16'hAAAA, 16'h0000, 1'b1, 1, 0);
    checks++;
    if (mem[10'h201] !== model(16'h0201)) begin
      errors++;
      $display("FAIL misalign_mem got=%h required=%h", mem[10'h201], model(16'h0201));
    end
`else
    run_txn("odd_fetch", 1'b0, 1'b0, 16'h0011, 16'h0000, model(16'h0011), 1'b0, 2, 0);
`endif
  endtask

  task automatic test_lat3();
    run_lat3("lat3_d", 1'b1, 16'h0300, 16'h595A);
  endtask

  task automatic test_reset_mid();
    int n_rv = 0;
    if_req3 = 1'b1; if_addr3 = 16'h0310;
    @(negedge clock);
    checks++;
    if (if_gnt3 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_gnt got=%b required=1", if_gnt3);
    end
    @(posedge clock); #1;
    if_req3 = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (busy3 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy_before got=%b required=1", busy3);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy3 !== 1'b0 || mem_we3 !== 1'b0 || if_rvalid3 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async busy=%b we=%b rv=%b required 0 0 0", busy3, mem_we3,
               if_rvalid3);
    end
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (if_rvalid3 || d_rvalid3) n_rv++;
    end
    checks++;
    if (n_rv != 0) begin
      errors++;
      $display("FAIL rst_mid_no_rvalid got=%0d required=0", n_rv);
    end
    @(posedge clock); #1;
    run_lat3("rst_mid_next", 1'b1, 16'h0320, 16'h597A);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = model(16'(i));
    mem[10'h010] = 16'hBEEF;
    test_reset();
    test_fetch();
    test_write_read();
    test_starvation();
    test_misaligned();
    test_lat3();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the instruction-fetch unit (port "if") and the load/store/stack unit (port "d").
- Arbitrates, sequences one access at a time, holds address and write data stable for the memory's read latency, and returns read data or a write acknowledge to the winner.
- Sits between the control unit/fetch logic and the memory datapath address/data muxes, which are driven from mem_addr/mem_wdata/mem_we.

Parameters:
- DATA_W, 16, width of address and data buses.
- MEM_LAT, 1, memory read latency in cycles (legal 1..3); mem_rdata is valid MEM_LAT cycles after the address is first presented.
- STARVE_MAX, 4, consecutive data-port wins tolerated while if_req is pending before fetch is forced to win.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- if_req  in  1  fetch request; held high with stable if_addr until if_gnt.
- if_addr  in  16  fetch address (pc).
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  16  registered fetch read data.
- d_req  in  1  data request; held high with stable d_we/d_addr/d_wdata until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  16  data address (sp+2, sp+imm, register, immediate as muxed upstream).
- d_wdata  in  16  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse; read data valid, or write complete.
- d_rdata  out  16  registered data read value (0 after writes).
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  16  memory read data.
- busy  out  1  high in any state other than IDLE.
- addr_err  out  1  misalignment flag (see Optional Feature).

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP. Reset state is IDLE. All outputs reset to 0, including mem_we and both rvalids.
- IDLE: grants are combinational, at most one per cycle, issued only in IDLE.
  - Only d_req high: d wins.
  - Only if_req high: if wins.
  - Both high: d wins, unless the starve counter equals STARVE_MAX, in which case if wins.
  - On grant: latch owner, addr, we, and wdata; go to ACCESS.
- Starve counter (3 bits, saturating at STARVE_MAX):
  - Increments on a d grant while if_req is high.
  - Clears on an if grant, or whenever if_req is low in IDLE.
- ACCESS (cycle A): mem_addr = latched addr; mem_wdata = latched wdata; mem_we = latched we for this cycle only.
  - Write: go to RESP.
  - Read with MEM_LAT = 1: go to RESP.
  - Read with MEM_LAT > 1: go to WAIT.
- WAIT: mem_addr held; mem_we = 0; latency counter advances; leaves to RESP after cycle A+MEM_LAT-1.
- Read data capture: mem_rdata is sampled into the owner's rdata register at the end of cycle A+MEM_LAT-1.
- RESP: owner's rvalid = 1 for exactly one cycle; next state IDLE. No back-to-back grant in RESP.
- Latency: read = 1 grant cycle + MEM_LAT + 1 RESP cycle, so rvalid arrives MEM_LAT+1 cycles after gnt. Write: d_rvalid arrives 2 cycles after d_gnt.
- Outside ACCESS/WAIT: mem_addr and mem_wdata hold their last value; mem_we = 0.
- A requester must not be granted twice for one req. A req that stays high after gnt is re-arbitrated only when the arbiter is next in IDLE.
- if_req with if writes: not possible; the fetch port is read-only.
- Reset mid-operation: the transaction is dropped, no rvalid is issued, mem_we deasserts asynchronously, and the starve counter clears.
- Width: address and data pass through unmodified; no arithmetic on addresses.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN.
- Enabled: a granted request with addr[0] = 1 skips ACCESS/WAIT and goes directly to RESP.
  - Memory untouched; mem_we never asserted.
  - rdata = 0; owner's rvalid pulses; addr_err pulses high together with rvalid.
- Disabled: addr[0] is ignored, and every request goes to memory. addr_err is tied 0.

Test Plan:
- MEM_LAT=1, if_req with if_addr=0x0010, memory holds 0xBEEF -> if_gnt same cycle, mem_addr=0x0010 next cycle, if_rvalid with if_rdata=0xBEEF 2 cycles after gnt.
- d_req write d_addr=0x0200, d_wdata=0x1234, then d read 0x0200 -> mem_we high exactly one cycle; d_rvalid after write; read returns d_rdata=0x1234.
- Both requesters continuously high, STARVE_MAX=4 -> grant order d,d,d,d,if,d,d,d,d,if; never two grants in one cycle.
- MEM_LAT=3 read -> mem_addr stable 3 cycles, mem_we=0 throughout, rvalid 4 cycles after gnt.
- Assert reset during WAIT of a read -> busy=0, mem_we=0 immediately; no rvalid after release; next request serviced normally from IDLE.
- With MEM_ARB_ALIGN_CHECK_EN, d write to 0x0201 -> mem_we never high, d_rvalid and addr_err pulse together, memory contents unchanged.
